// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic [2:0] {
      S_START  = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } fetch_state_t;

   // Fetch timeout: cycles allowed in S_FETCH without an ack
   localparam int          MEM_TIMEOUT = 16;
   localparam int          CNT_W       = 5;

   localparam logic [3:0]  OPC_BR      = 4'h0;
   localparam logic [3:0]  OPC_JMP     = 4'hC;
   localparam logic [3:0]  OPC_TRAP    = 4'hF;
   localparam logic [7:0]  HALT_VEC    = 8'h25;

   function automatic logic is_halt(input logic [15:0] instr);
      return (instr[15:12] == OPC_TRAP) && (instr[7:0] == HALT_VEC);
   endfunction

   function automatic logic is_branch_or_jump(input logic [15:0] instr);
      return (instr[15:12] == OPC_BR) || (instr[15:12] == OPC_JMP);
   endfunction

   // Control instructions are resolved locally and never sent downstream
   function automatic logic is_control(input logic [15:0] instr);
      return is_branch_or_jump(instr) || is_halt(instr);
   endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational PC steering for the execute step of BR and JMP.
// JMP loads the base register value; BR adds the signed offset when any
// selected condition code is set, otherwise holds the PC (offset 0).
module branch_resolve
   import fetch_pkg::*;
(
   input  logic [15:0] i_ir,
   input  logic [2:0]  i_nzp,
   input  logic [15:0] i_base_value,
   output logic        o_load_en,
   output logic [15:0] o_load_val,
   output logic        o_off_en,
   output logic [8:0]  o_offset
);

   logic w_is_jmp;
   logic w_is_br;
   logic w_taken;

   assign w_is_jmp = (i_ir[15:12] == OPC_JMP);
   assign w_is_br  = (i_ir[15:12] == OPC_BR);
   assign w_taken  = |(i_ir[11:9] & i_nzp);

   // Select load for JMP, otherwise offset mode (hold when not taken)
   always_comb begin
      o_load_en  = 1'b0;
      o_load_val = 16'h0000;
      o_off_en   = 1'b0;
      o_offset   = 9'h000;
      if (w_is_jmp) begin
         o_load_en  = 1'b1;
         o_load_val = i_base_value;
      end else begin
         o_off_en = 1'b1;
         if (w_is_br && w_taken) begin
            o_offset = i_ir[8:0];
         end
      end
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch/sequencing stage: fetches instructions at the PC, hands non-control
// instructions downstream and resolves BR/JMP/HALT by steering the PC.
// The external PC increments every edge unless steered; "hold" means offset
// enable with a zero offset.
//
// Downstream handshake: o_instr_valid rises in S_DECODE for a non-control
// instruction and stays high, with o_instr_out unchanged, until a cycle in
// which i_instr_ready is also high; the transfer happens on that edge.
module instruction_fetch_unit
   import fetch_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [15:0]  i_pc_value,
   output logic         o_pc_load_enable,
   output logic [15:0]  o_pc_load_value,
   output logic         o_pc_offset_enable,
   output logic [8:0]   o_pc_offset,
   output logic         o_mem_req,
   output logic [15:0]  o_mem_addr,
   input  logic         i_mem_ack,
   input  logic [15:0]  i_mem_rdata,
   output logic         o_instr_valid,
   output logic [15:0]  o_instr_out,
   input  logic         i_instr_ready,
   input  logic [2:0]   i_nzp,
   output logic [2:0]   o_base_reg,
   input  logic [15:0]  i_base_value,
   output logic         o_halted,
   output logic         o_fetch_error,
   output fetch_state_t o_state
);

   fetch_state_t     r_state;
   logic [15:0]      r_ir;
   logic [CNT_W-1:0] r_cnt;
   logic             r_halted;
   logic             r_fetch_error;

   logic             w_br_load_en;
   logic [15:0]      w_br_load_val;
   logic             w_br_off_en;
   logic [8:0]       w_br_offset;

   branch_resolve u_branch_resolve (
      .i_ir         (r_ir),
      .i_nzp        (i_nzp),
      .i_base_value (i_base_value),
      .o_load_en    (w_br_load_en),
      .o_load_val   (w_br_load_val),
      .o_off_en     (w_br_off_en),
      .o_offset     (w_br_offset)
   );

   // Sequencing FSM with instruction register, timeout counter and sticky flags
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_START;
         r_ir          <= 16'h0000;
         r_cnt         <= '0;
         r_halted      <= 1'b0;
         r_fetch_error <= 1'b0;
      end else begin
         case (r_state)
            S_START: begin
               r_state <= S_FETCH;
            end
            S_FETCH: begin
               if (i_mem_ack) begin
                  r_ir    <= i_mem_rdata;
                  r_cnt   <= '0;
                  r_state <= S_DECODE;
               end else if (r_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                  r_fetch_error <= 1'b1;
                  r_cnt         <= '0;
                  r_state       <= S_HALT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DECODE: begin
               if (is_halt(r_ir)) begin
                  r_halted <= 1'b1;
                  r_state  <= S_HALT;
               end else if (is_branch_or_jump(r_ir)) begin
                  r_state <= S_EXEC;
               end else if (i_instr_ready) begin
                  r_state <= S_FETCH;
               end
            end
            S_EXEC: begin
               r_state <= S_FETCH;
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state <= S_HALT;
            end
         endcase
      end
   end

   // PC steering, memory request and downstream valid decoded from state and IR
   always_comb begin
      o_pc_load_enable   = 1'b0;
      o_pc_load_value    = 16'h0000;
      o_pc_offset_enable = 1'b0;
      o_pc_offset        = 9'h000;
      o_mem_req          = 1'b0;
      o_instr_valid      = 1'b0;
      case (r_state)
         S_START: begin
            o_pc_offset_enable = 1'b1;
         end
         S_FETCH: begin
            o_mem_req          = 1'b1;
            o_pc_offset_enable = 1'b1;
         end
         S_DECODE: begin
            if (is_halt(r_ir)) begin
               o_pc_offset_enable = 1'b1;
            end else if (!is_control(r_ir)) begin
               o_instr_valid = 1'b1;
               // Stall holds the PC; acceptance lets it increment
               o_pc_offset_enable = !i_instr_ready;
            end
         end
         S_EXEC: begin
            o_pc_load_enable   = w_br_load_en;
            o_pc_load_value    = w_br_load_val;
            o_pc_offset_enable = w_br_off_en;
            o_pc_offset        = w_br_offset;
         end
         default: begin
            o_pc_offset_enable = 1'b1;
         end
      endcase
   end

   assign o_mem_addr    = i_pc_value;
   assign o_instr_out   = r_ir;
   assign o_base_reg    = r_ir[8:6];
   assign o_halted      = r_halted;
   assign o_fetch_error = r_fetch_error;
   assign o_state       = r_state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a PC model and memory responder.
module tb_instruction_fetch_unit;
   import fetch_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [15:0]  pc;
   logic         pc_load_enable;
   logic [15:0]  pc_load_value;
   logic         pc_offset_enable;
   logic [8:0]   pc_offset;
   logic         mem_req;
   logic [15:0]  mem_addr;
   logic         mem_ack = 1'b0;
   logic [15:0]  mem_rdata = 16'h0000;
   logic         instr_valid;
   logic [15:0]  instr_out;
   logic         instr_ready = 1'b1;
   logic [2:0]   nzp = 3'b000;
   logic [2:0]   base_reg;
   logic [15:0]  base_value = 16'h0000;
   logic         halted;
   logic         fetch_error;
   fetch_state_t dut_state;

   int           n_pass = 0;
   int           n_total = 0;

   logic [15:0]  mem [int];
   bit           mem_on = 1'b1;
   logic [15:0]  addr_log[$];
   logic [15:0]  instr_log[$];
   logic [15:0]  exp_q[$];
   logic [8:0]   last_off;
   logic [15:0]  pc_at_off;
   logic [2:0]   last_base_reg;

   instruction_fetch_unit dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_pc_value         (pc),
      .o_pc_load_enable   (pc_load_enable),
      .o_pc_load_value    (pc_load_value),
      .o_pc_offset_enable (pc_offset_enable),
      .o_pc_offset        (pc_offset),
      .o_mem_req          (mem_req),
      .o_mem_addr         (mem_addr),
      .i_mem_ack          (mem_ack),
      .i_mem_rdata        (mem_rdata),
      .o_instr_valid      (instr_valid),
      .o_instr_out        (instr_out),
      .i_instr_ready      (instr_ready),
      .i_nzp              (nzp),
      .o_base_reg         (base_reg),
      .i_base_value       (base_value),
      .o_halted           (halted),
      .o_fetch_error      (fetch_error),
      .o_state            (dut_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // Program counter model: load wins, offset adds sext(off9), else +1
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc <= 16'h0000;
      else if (pc_load_enable) pc <= pc_load_value;
      else if (pc_offset_enable) pc <= pc + {{7{pc_offset[8]}}, pc_offset};
      else pc <= pc + 16'h0001;
   end

   function automatic logic [15:0] mem_rd(input logic [15:0] a);
      if (mem.exists(int'(a))) return mem[int'(a)];
      return 16'h1021;
   endfunction

   // Memory responder: ack one cycle into each request
   initial begin
      forever begin
         @(negedge clk);
         if (mem_on && rst_n && mem_req && !mem_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_rd(mem_addr);
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = 16'h0000;
         end
      end
   end

   // Monitor: records transfers that complete on the coming edge
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst_n) begin
            if (mem_req && mem_ack) addr_log.push_back(mem_addr);
            if (instr_valid && instr_ready) instr_log.push_back(instr_out);
            if (pc_offset_enable && pc_offset != 9'h000) begin
               last_off  = pc_offset;
               pc_at_off = pc;
            end
            if (pc_load_enable) last_base_reg = base_reg;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic hold_reset();
      rst_n = 1'b0;
      mem.delete();
      addr_log.delete();
      instr_log.delete();
      mem_on        = 1'b1;
      instr_ready   = 1'b1;
      nzp           = 3'b000;
      base_value    = 16'h0000;
      last_off      = 9'h000;
      pc_at_off     = 16'h0000;
      last_base_reg = 3'b000;
      repeat (3) @(negedge clk);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_stop(input int budget, output bit ok);
      int n = 0;
      while (!(halted || fetch_error) && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      ok = halted || fetch_error;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      hold_reset();
      #1;
      n_total++;
      if ({mem_req, instr_valid, pc_load_enable} !== 3'b000)
         $display("FAIL reset_outputs: req/valid/load=%b want 000", {mem_req, instr_valid, pc_load_enable});
      else n_pass++;
      n_total++;
      if ({pc_offset_enable, pc_offset} !== {1'b1, 9'h000})
         $display("FAIL reset_hold: off_en=%b off=%h want 1/000", pc_offset_enable, pc_offset);
      else n_pass++;
      n_total++;
      if ({halted, fetch_error, instr_out, dut_state} !== {2'b00, 16'h0000, S_START})
         $display("FAIL reset_state: halted=%b err=%b ir=%h st=%0d want 0/0/0000/0", halted, fetch_error, instr_out, dut_state);
      else n_pass++;
   endtask

   task automatic test_sequential();
      bit ok;
      hold_reset();
      mem[0] = 16'h1021; mem[1] = 16'h1021; mem[2] = 16'hF025;
      release_reset();
      wait_stop(60, ok);
      n_total++;
      if (!ok) $display("FAIL seq_timeout: no halt within budget");
      else n_pass++;
      exp_q = '{16'h0000, 16'h0001, 16'h0002};
      n_total++;
      if (addr_log.size() != exp_q.size()) $display("FAIL seq_naddr: got %0d want %0d", addr_log.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < addr_log.size(); i++) begin
         n_total++;
         if (addr_log[i] !== exp_q[i]) $display("FAIL seq_addr[%0d]: got %h want %h", i, addr_log[i], exp_q[i]);
         else n_pass++;
      end
      n_total++;
      if (instr_log.size() != 2 || instr_log[0] !== 16'h1021 || instr_log[1] !== 16'h1021)
         $display("FAIL seq_instr: got n=%0d want two 1021", instr_log.size());
      else n_pass++;
      n_total++;
      if ({pc, halted, mem_req, instr_valid} !== {16'h0002, 3'b100})
         $display("FAIL seq_end: pc=%h halted=%b req=%b valid=%b want 0002/1/0/0", pc, halted, mem_req, instr_valid);
      else n_pass++;
   endtask

   task automatic test_branch_forward();
      bit ok;
      hold_reset();
      nzp = 3'b010;
      mem[0] = 16'h1021; mem[1] = 16'h1021; mem[2] = 16'h1021;
      mem[3] = 16'h0E05; mem[9] = 16'hF025;
      release_reset();
      wait_stop(80, ok);
      exp_q = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0009};
      n_total++;
      if (!ok || addr_log.size() != exp_q.size()) $display("FAIL brf_naddr: got %0d want %0d", addr_log.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < addr_log.size(); i++) begin
         n_total++;
         if (addr_log[i] !== exp_q[i]) $display("FAIL brf_addr[%0d]: got %h want %h", i, addr_log[i], exp_q[i]);
         else n_pass++;
      end
      n_total++;
      if (last_off !== 9'd5 || pc_at_off !== 16'h0004)
         $display("FAIL brf_exec: off=%h pc=%h want 005/0004", last_off, pc_at_off);
      else n_pass++;
   endtask

   task automatic test_branch_backward(input logic [2:0] cc, input logic [15:0] next_addr);
      bit ok;
      hold_reset();
      nzp = cc;
      base_value = 16'h000A;
      mem[0] = 16'hC1C0; mem[10] = 16'h05FE;
      mem[9] = 16'hF025; mem[11] = 16'hF025;
      release_reset();
      wait_stop(60, ok);
      exp_q = '{16'h0000, 16'h000A, next_addr};
      n_total++;
      if (!ok || addr_log.size() != exp_q.size()) $display("FAIL brb_naddr nzp=%b: got %0d want %0d", cc, addr_log.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < addr_log.size(); i++) begin
         n_total++;
         if (addr_log[i] !== exp_q[i]) $display("FAIL brb_addr[%0d] nzp=%b: got %h want %h", i, cc, addr_log[i], exp_q[i]);
         else n_pass++;
      end
      n_total++;
      if (pc !== next_addr) $display("FAIL brb_pc nzp=%b: got %h want %h", cc, pc, next_addr);
      else n_pass++;
   endtask

   task automatic test_jump();
      bit ok;
      hold_reset();
      base_value = 16'h3000;
      mem[0] = 16'hC1C0; mem[16'h3000] = 16'hF025;
      release_reset();
      wait_stop(60, ok);
      n_total++;
      if (!ok || addr_log.size() != 2 || addr_log[0] !== 16'h0000 || addr_log[1] !== 16'h3000)
         $display("FAIL jmp_addr: got n=%0d want 0000,3000", addr_log.size());
      else n_pass++;
      n_total++;
      if (last_base_reg !== 3'd7) $display("FAIL jmp_basereg: got %0d want 7", last_base_reg);
      else n_pass++;
      n_total++;
      if (pc !== 16'h3000) $display("FAIL jmp_pc: got %h want 3000", pc);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      bit ok;
      int n = 0;
      hold_reset();
      instr_ready = 1'b0;
      mem[0] = 16'h1234; mem[1] = 16'hF025;
      release_reset();
      while (!instr_valid && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      for (int c = 0; c < 4; c++) begin
         n_total++;
         if ({instr_valid, instr_out, pc} !== {1'b1, 16'h1234, 16'h0000})
            $display("FAIL bp_stall[%0d]: valid=%b ir=%h pc=%h want 1/1234/0000", c, instr_valid, instr_out, pc);
         else n_pass++;
         @(negedge clk);
         #1;
      end
      instr_ready = 1'b1;
      @(negedge clk);
      #1;
      n_total++;
      if (pc !== 16'h0001 || instr_valid !== 1'b0)
         $display("FAIL bp_accept: pc=%h valid=%b want 0001/0", pc, instr_valid);
      else n_pass++;
      wait_stop(40, ok);
      n_total++;
      if (!ok || instr_log.size() != 1 || instr_log[0] !== 16'h1234)
         $display("FAIL bp_once: transfers=%0d want one 1234", instr_log.size());
      else n_pass++;
   endtask

   task automatic test_timeout();
      int fetch_cycles = 0;
      int n = 0;
      hold_reset();
      mem_on = 1'b0;
      release_reset();
      while (!fetch_error && n < 60) begin
         @(negedge clk);
         #1;
         if (mem_req) fetch_cycles++;
         n++;
      end
      n_total++;
      if (fetch_cycles != MEM_TIMEOUT) $display("FAIL to_cycles: got %0d want %0d", fetch_cycles, MEM_TIMEOUT);
      else n_pass++;
      repeat (3) @(negedge clk);
      #1;
      n_total++;
      if ({fetch_error, halted, mem_req, pc, dut_state} !== {3'b100, 16'h0000, S_HALT})
         $display("FAIL to_state: err=%b halted=%b req=%b pc=%h st=%0d want 1/0/0/0000/4", fetch_error, halted, mem_req, pc, dut_state);
      else n_pass++;
   endtask

   task automatic test_halt();
      bit ok;
      logic [15:0] pc_snap;
      hold_reset();
      mem[0] = 16'hF025;
      release_reset();
      wait_stop(30, ok);
      pc_snap = pc;
      repeat (5) @(negedge clk);
      #1;
      n_total++;
      if (!ok || {halted, fetch_error, mem_req, instr_valid} !== 4'b1000)
         $display("FAIL halt_flags: halted=%b err=%b req=%b valid=%b want 1/0/0/0", halted, fetch_error, mem_req, instr_valid);
      else n_pass++;
      n_total++;
      if (pc !== 16'h0000 || pc !== pc_snap) $display("FAIL halt_pc: got %h want 0000", pc);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      int n = 0;
      hold_reset();
      mem_on = 1'b0;
      release_reset();
      while (!mem_req && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      n_total++;
      if (mem_req !== 1'b1) $display("FAIL ar_req_up: got %b want 1", mem_req);
      else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({mem_req, pc_offset_enable, dut_state} !== {2'b01, S_START})
         $display("FAIL ar_drop: req=%b off_en=%b st=%0d want 0/1/0", mem_req, pc_offset_enable, dut_state);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_sequential();
      test_branch_forward();
      test_branch_backward(3'b010, 16'h0009);
      test_branch_backward(3'b100, 16'h000B);
      test_jump();
      test_backpressure();
      test_timeout();
      test_halt();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
